// File: rtl/alu_pkg.sv
// alu_pkg: ALU select codes and the writeback FIFO entry layout shared with the ALU and decode.
package alu_pkg;
  localparam int SEL_W = 5;
  localparam logic [SEL_W-1:0] SEL_ADD = 5'd1;
  localparam logic [SEL_W-1:0] SEL_SUB = 5'd2;
  localparam logic [SEL_W-1:0] SEL_MUL = 5'd3;
  localparam logic [SEL_W-1:0] SEL_DIV = 5'd4;
  localparam int WB_DATA_W = 32;
  localparam int WB_RA_W = 5;
  typedef struct packed {
    logic [2*WB_DATA_W-1:0] result;
    logic [SEL_W-1:0]       sel;
    logic [WB_RA_W-1:0]     rd;
    logic                   wen;
  } wb_entry_t;
  localparam int WB_ENTRY_W = $bits(wb_entry_t);
  function automatic logic is_hilo(input logic [SEL_W-1:0] s);
    return s == SEL_MUL || s == SEL_DIV;
  endfunction
  function automatic logic is_addsub(input logic [SEL_W-1:0] s);
    return s == SEL_ADD || s == SEL_SUB;
  endfunction
endpackage

// File: rtl/alu_wb_skid_fifo.sv
// alu_wb_skid_fifo: 2-entry FIFO with flush; exposes head and youngest entry for forwarding.
module alu_wb_skid_fifo #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] head_o,
  output logic [W-1:0] young_o,
  output logic [1:0]   count_o
);
  logic [W-1:0] mem_q [2];
  logic wr_q, rd_q;
  logic [1:0] cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else if (flush_i) begin
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (push_i) wr_q <= ~wr_q;
      if (pop_i) rd_q <= ~rd_q;
      cnt_q <= cnt_q + 2'(push_i) - 2'(pop_i);
    end
  always_ff @(posedge clk)
    if (push_i && !flush_i) mem_q[wr_q] <= din_i;
  // with one entry buffered, head and youngest are the same slot
  assign head_o  = mem_q[rd_q];
  assign young_o = mem_q[~wr_q];
  assign count_o = cnt_q;
endmodule

// File: rtl/alu_writeback.sv
// alu_writeback: ALU writeback stage with skid buffer, HI/LO and forwarding lookup.
// Optional overflow trap on ADD/SUB enabled by defining ALU_WB_OVF_TRAP_EN.
module alu_writeback import alu_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int SEL_W  = 5,
  parameter int RA_W   = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ex_valid,
  output logic                ex_ready,
  input  logic [2*DATA_W-1:0] ex_result,
  input  logic [SEL_W-1:0]    ex_sel,
  input  logic [RA_W-1:0]     ex_rd,
  input  logic                ex_wen,
  input  logic                flush,
  input  logic                rf_busy,
  output logic                rf_we,
  output logic [RA_W-1:0]     rf_waddr,
  output logic [DATA_W-1:0]   rf_wdata,
  output logic [DATA_W-1:0]   hi_q,
  output logic [DATA_W-1:0]   lo_q,
`ifdef ALU_WB_OVF_TRAP_EN
  output logic                ovf_trap,
  output logic                ovf_sticky,
`endif
  input  logic [RA_W-1:0]     lu_rd,
  output logic                lu_hit,
  output logic [DATA_W-1:0]   lu_data
);
  typedef struct packed {
    logic [2*DATA_W-1:0] result;
    logic [SEL_W-1:0]    sel;
    logic [RA_W-1:0]     rd;
    logic                wen;
  } ent_t;
  ent_t in_e, head, young;
  logic [1:0] cnt;
  logic push, pop, ovf_h, ovf_y, hit_y, hit_o, hit_r, we_d, ld_d, hl_d;
  assign in_e     = {ex_result, ex_sel, ex_rd, ex_wen};
  assign ex_ready = cnt != 2'd2;
  assign push     = ex_valid & ex_ready & ~flush;
  assign pop      = (cnt != 2'd0) & ~rf_busy & ~flush;
  alu_wb_skid_fifo #(.W($bits(ent_t))) u_fifo (
    .clk(clk), .rst_n(rst_n), .push_i(push), .pop_i(pop), .flush_i(flush),
    .din_i(in_e), .head_o(head), .young_o(young), .count_o(cnt)
  );
`ifdef ALU_WB_OVF_TRAP_EN
  function automatic logic ovf(input ent_t e);
    return is_addsub(e.sel) && e.result[2*DATA_W-1:DATA_W] != {DATA_W{e.result[DATA_W-1]}};
  endfunction
  assign ovf_h = ovf(head);
  assign ovf_y = ovf(young);
  logic trap_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      trap_q     <= 1'b0;
      ovf_sticky <= 1'b0;
    end else begin
      trap_q     <= pop & ovf_h;
      ovf_sticky <= ovf_sticky | (pop & ovf_h);
    end
  assign ovf_trap = trap_q;
`else
  assign ovf_h = 1'b0;
  assign ovf_y = 1'b0;
  logic unused_upper;
  assign unused_upper = &{1'b0, young.result[2*DATA_W-1:DATA_W]};
`endif
  function automatic logic fwd(input ent_t e, input logic ov, input logic [RA_W-1:0] a);
    return e.wen && e.rd == a && e.rd != '0 && !is_hilo(e.sel) && !ov;
  endfunction
  // youngest FIFO entry wins, then the older one, then the write already on the port
  always_comb begin
    hit_y   = cnt != 2'd0 && fwd(young, ovf_y, lu_rd);
    hit_o   = cnt == 2'd2 && fwd(head, ovf_h, lu_rd);
    hit_r   = rf_we && rf_waddr == lu_rd;
    lu_hit  = hit_y | hit_o | hit_r;
    lu_data = hit_y ? young.result[DATA_W-1:0] : hit_o ? head.result[DATA_W-1:0] : hit_r ? rf_wdata : '0;
    hl_d    = pop & is_hilo(head.sel);
    ld_d    = pop & ~is_hilo(head.sel);
    we_d    = ld_d & head.wen & (head.rd != '0) & ~ovf_h;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      rf_we <= we_d;
      if (ld_d) begin
        rf_waddr <= head.rd;
        rf_wdata <= head.result[DATA_W-1:0];
      end
      if (hl_d) begin
        hi_q <= head.result[2*DATA_W-1:DATA_W];
        lo_q <= head.result[DATA_W-1:0];
      end
    end
endmodule

// File: tb/tb_alu_writeback.sv
// tb_alu_writeback: directed scenarios plus randomized run against a queue-based reference model.
module tb_alu_writeback;
  logic clk = 1'b0, rst_n = 1'b0, ex_valid = 1'b0, ex_wen = 1'b0, flush = 1'b0, rf_busy = 1'b0;
  logic [63:0] ex_result = '0;
  logic [4:0] ex_sel = '0, ex_rd = '0, lu_rd = '0;
  logic ex_ready, rf_we, lu_hit;
  logic [4:0] rf_waddr;
  logic [31:0] rf_wdata, hi_q, lo_q, lu_data;
`ifdef ALU_WB_OVF_TRAP_EN
  logic ovf_trap, ovf_sticky;
`endif
  alu_writeback dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_result(ex_result),
    .ex_sel(ex_sel), .ex_rd(ex_rd), .ex_wen(ex_wen), .flush(flush), .rf_busy(rf_busy),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .hi_q(hi_q), .lo_q(lo_q),
`ifdef ALU_WB_OVF_TRAP_EN
    .ovf_trap(ovf_trap), .ovf_sticky(ovf_sticky),
`endif
    .lu_rd(lu_rd), .lu_hit(lu_hit), .lu_data(lu_data)
  );
  always #5 clk = ~clk;

  typedef struct { logic [63:0] r; logic [4:0] s; logic [4:0] d; logic w; } ent_t;
  ent_t q[$];
  logic m_we, m_trap, m_sticky;
  logic [4:0] m_wa;
  logic [31:0] m_wd, m_hi, m_lo;
  int n_cmp = 0, n_bad = 0;

  function automatic bit m_ovf(ent_t e);
`ifdef ALU_WB_OVF_TRAP_EN
    return (e.s == 5'd1 || e.s == 5'd2) &&
           ($signed(e.r) > 64'sd2147483647 || $signed(e.r) < -64'sd2147483648);
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit m_fwd(ent_t e, logic [4:0] a);
    return e.w && e.d == a && e.d != 0 && e.s != 5'd3 && e.s != 5'd4 && !m_ovf(e);
  endfunction

  task automatic m_lookup(output logic hit, output logic [31:0] data);
    hit = 1'b0;
    data = '0;
    for (int i = q.size() - 1; i >= 0; i--)
      if (!hit && m_fwd(q[i], lu_rd)) begin hit = 1'b1; data = q[i].r[31:0]; end
    if (!hit && m_we && m_wa == lu_rd) begin hit = 1'b1; data = m_wd; end
  endtask

  task automatic m_clear();
    q.delete();
    m_we = 0; m_wa = 0; m_wd = 0; m_hi = 0; m_lo = 0; m_trap = 0; m_sticky = 0;
  endtask

  task automatic tick();
    bit rdy, psh, pp;
    ent_t e, h;
    rdy = q.size() < 2;
    psh = ex_valid && rdy && !flush;
    pp  = q.size() > 0 && !rf_busy && !flush;
    e   = '{ex_result, ex_sel, ex_rd, ex_wen};
    @(posedge clk);
    m_we = 0;
    m_trap = 0;
    if (flush) q.delete();
    else begin
      if (pp) begin
        h = q.pop_front();
        if (h.s == 5'd3 || h.s == 5'd4) begin
          m_hi = h.r[63:32];
          m_lo = h.r[31:0];
        end else begin
          m_wa = h.d;
          m_wd = h.r[31:0];
          m_we = h.w && h.d != 0 && !m_ovf(h);
          m_trap = m_ovf(h);
        end
      end
      if (psh) q.push_back(e);
    end
    m_sticky |= m_trap;
    @(negedge clk);
  endtask

  task automatic drive(logic [63:0] r, logic [4:0] s, logic [4:0] d, logic w);
    ex_valid = 1; ex_result = r; ex_sel = s; ex_rd = d; ex_wen = w;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++; if (rf_we !== 1'b0) begin n_bad++; $display("FAIL reset_we got %0h want 0", rf_we); end
    n_cmp++; if (rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin n_bad++; $display("FAIL reset_wr got %0h/%0h want 0/0", rf_waddr, rf_wdata); end
    n_cmp++; if (hi_q !== 32'd0 || lo_q !== 32'd0) begin n_bad++; $display("FAIL reset_hilo got %0h/%0h want 0/0", hi_q, lo_q); end
    n_cmp++; if (lu_hit !== 1'b0 || ex_ready !== 1'b1) begin n_bad++; $display("FAIL reset_hit_rdy got %0b/%0b want 0/1", lu_hit, ex_ready); end
    m_clear();
    @(negedge clk) rst_n = 1;
  endtask

  task automatic test_add();
    drive(64'hC, 5'd1, 5'd3, 1'b1);
    tick();
    ex_valid = 0;
    n_cmp++; if (rf_we !== 1'b0) begin n_bad++; $display("FAIL add_lat got %0b want 0", rf_we); end
    tick();
    n_cmp++; if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'hC) begin n_bad++; $display("FAIL add_wr got %0b/%0d/%0h want 1/3/c", rf_we, rf_waddr, rf_wdata); end
    tick();
    n_cmp++; if (rf_we !== 1'b0) begin n_bad++; $display("FAIL add_pulse got %0b want 0", rf_we); end
  endtask

  task automatic test_mul();
    drive(64'h0000_0001_0000_0002, 5'd3, 5'd5, 1'b1);
    tick();
    ex_valid = 0;
    lu_rd = 5'd5;
    #1;
    n_cmp++; if (lu_hit !== 1'b0) begin n_bad++; $display("FAIL mul_lookup got %0b want 0", lu_hit); end
    tick();
    n_cmp++; if (hi_q !== 32'd1 || lo_q !== 32'd2 || rf_we !== 1'b0) begin n_bad++; $display("FAIL mul_hilo got %0h/%0h/%0b want 1/2/0", hi_q, lo_q, rf_we); end
  endtask

  task automatic test_back_to_back();
    rf_busy = 1;
    drive(64'h101, 5'd0, 5'd1, 1'b1);
    tick();
    n_cmp++; if (ex_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_rdy1 got %0b want 1", ex_ready); end
    drive(64'h202, 5'd0, 5'd2, 1'b1);
    tick();
    n_cmp++; if (ex_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_full got %0b want 0", ex_ready); end
    drive(64'h303, 5'd0, 5'd3, 1'b1);
    tick();
    n_cmp++; if (ex_ready !== 1'b0 || rf_we !== 1'b0) begin n_bad++; $display("FAIL b2b_hold got %0b/%0b want 0/0", ex_ready, rf_we); end
    rf_busy = 0;
    tick();
    n_cmp++; if (rf_we !== 1'b1 || rf_waddr !== 5'd1 || rf_wdata !== 32'h101 || ex_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_pop1 got %0b/%0d/%0h/%0b want 1/1/101/1", rf_we, rf_waddr, rf_wdata, ex_ready); end
    tick();
    ex_valid = 0;
    n_cmp++; if (rf_we !== 1'b1 || rf_waddr !== 5'd2 || rf_wdata !== 32'h202) begin n_bad++; $display("FAIL b2b_pop2 got %0b/%0d/%0h want 1/2/202", rf_we, rf_waddr, rf_wdata); end
    tick();
    n_cmp++; if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'h303) begin n_bad++; $display("FAIL b2b_pop3 got %0b/%0d/%0h want 1/3/303", rf_we, rf_waddr, rf_wdata); end
    tick();
    n_cmp++; if (rf_we !== 1'b0) begin n_bad++; $display("FAIL b2b_drain got %0b want 0", rf_we); end
  endtask

  task automatic test_lookup_flush();
    rf_busy = 1;
    drive(64'h11, 5'd1, 5'd7, 1'b1);
    tick();
    drive(64'h22, 5'd1, 5'd7, 1'b1);
    tick();
    ex_valid = 0;
    lu_rd = 5'd7;
    #1;
    n_cmp++; if (lu_hit !== 1'b1 || lu_data !== 32'h22) begin n_bad++; $display("FAIL lu_young got %0b/%0h want 1/22", lu_hit, lu_data); end
    flush = 1;
    tick();
    flush = 0;
    n_cmp++; if (ex_ready !== 1'b1 || rf_we !== 1'b0 || lu_hit !== 1'b0) begin n_bad++; $display("FAIL flush got %0b/%0b/%0b want 1/0/0", ex_ready, rf_we, lu_hit); end
    rf_busy = 0;
    tick();
    n_cmp++; if (rf_we !== 1'b0) begin n_bad++; $display("FAIL flush_drain got %0b want 0", rf_we); end
  endtask

  task automatic test_rd0();
    drive({$urandom, $urandom}, 5'd0, 5'd0, 1'b1);
    tick();
    ex_valid = 0;
    lu_rd = 5'd0;
    #1;
    n_cmp++; if (lu_hit !== 1'b0) begin n_bad++; $display("FAIL rd0_lookup got %0b want 0", lu_hit); end
    tick();
    n_cmp++; if (rf_we !== 1'b0) begin n_bad++; $display("FAIL rd0_we got %0b want 0", rf_we); end
  endtask

  task automatic test_ovf();
    drive(64'h0000_0000_8000_0000, 5'd1, 5'd9, 1'b1);
    tick();
    ex_valid = 0;
    tick();
`ifdef ALU_WB_OVF_TRAP_EN
    n_cmp++; if (rf_we !== 1'b0 || ovf_trap !== 1'b1 || ovf_sticky !== 1'b1) begin n_bad++; $display("FAIL ovf_trap got %0b/%0b/%0b want 0/1/1", rf_we, ovf_trap, ovf_sticky); end
    tick();
    n_cmp++; if (ovf_trap !== 1'b0 || ovf_sticky !== 1'b1) begin n_bad++; $display("FAIL ovf_pulse got %0b/%0b want 0/1", ovf_trap, ovf_sticky); end
`else
    n_cmp++; if (rf_we !== 1'b1 || rf_wdata !== 32'h8000_0000) begin n_bad++; $display("FAIL ovf_write got %0b/%0h want 1/80000000", rf_we, rf_wdata); end
`endif
  endtask

  task automatic test_random();
    logic eh;
    logic [31:0] ed, t;
    for (int i = 0; i < 400; i++) begin
      t = $urandom;
      ex_valid  = ($urandom % 4) != 0;
      ex_result = ($urandom % 2) ? {{32{t[31]}}, t} : {$urandom, t};
      ex_sel    = 5'($urandom_range(0, 6));
      ex_rd     = 5'($urandom_range(0, 7));
      ex_wen    = ($urandom % 4) != 0;
      flush     = ($urandom % 16) == 0;
      rf_busy   = ($urandom % 3) == 0;
      lu_rd     = 5'($urandom_range(0, 7));
      #1;
      m_lookup(eh, ed);
      n_cmp++; if (ex_ready !== (q.size() < 2)) begin n_bad++; $display("FAIL rnd_ready i=%0d got %0b want %0b", i, ex_ready, q.size() < 2); end
      n_cmp++; if (lu_hit !== eh || lu_data !== ed) begin n_bad++; $display("FAIL rnd_lookup i=%0d got %0b/%0h want %0b/%0h", i, lu_hit, lu_data, eh, ed); end
      if (i == 200) begin
        #1 rst_n = 0;
        #1;
        n_cmp++; if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0 || hi_q !== 32'd0 || lo_q !== 32'd0 || lu_hit !== 1'b0) begin n_bad++; $display("FAIL rnd_async_reset got %0b/%0h/%0h/%0h/%0h/%0b want all 0", rf_we, rf_waddr, rf_wdata, hi_q, lo_q, lu_hit); end
        m_clear();
        @(negedge clk) rst_n = 1;
        continue;
      end
      tick();
      n_cmp++; if (rf_we !== m_we || rf_waddr !== m_wa || rf_wdata !== m_wd) begin n_bad++; $display("FAIL rnd_wr i=%0d got %0b/%0d/%0h want %0b/%0d/%0h", i, rf_we, rf_waddr, rf_wdata, m_we, m_wa, m_wd); end
      n_cmp++; if (hi_q !== m_hi || lo_q !== m_lo) begin n_bad++; $display("FAIL rnd_hilo i=%0d got %0h/%0h want %0h/%0h", i, hi_q, lo_q, m_hi, m_lo); end
`ifdef ALU_WB_OVF_TRAP_EN
      n_cmp++; if (ovf_trap !== m_trap || ovf_sticky !== m_sticky) begin n_bad++; $display("FAIL rnd_ovf i=%0d got %0b/%0b want %0b/%0b", i, ovf_trap, ovf_sticky, m_trap, m_sticky); end
`endif
    end
    ex_valid = 0;
    flush = 0;
    rf_busy = 0;
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul();
    test_back_to_back();
    test_lookup_flush();
    test_rd0();
    test_ovf();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
